cmp_sort_ctrl: RTL and testbench
================================

# cmp_sort_ctrl

Sequencer that loads a burst of `N` unsigned words and sorts them in ascending order using a single shared greater-than comparator (`a > b ? 1 : 0`), one compare-and-swap per clock. The sorted words are then streamed out. It sits between a producer and a consumer, with valid/ready handshakes on both sides. It is the controller that time-multiplexes the comparator over the internal word buffer.

## Interface
- `N`, 4, number of words per burst; legal range 2..16.
- `WIDTH`, 8, word width in bits; words are compared as unsigned values.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  producer has a word on `in_data`.
- `in_ready`  output  1  block accepts a word this cycle.
- `in_data`  input  WIDTH  input word.
- `out_valid`  output  1  sorted word available on `out_data`.
- `out_ready`  input  1  consumer accepts `out_data` this cycle.
- `out_data`  output  WIDTH  sorted word; driven to 0 when `out_valid` = 0.
- `busy`  output  1  high while in SORT or DRAIN.

## Operation
- Storage: buffer `mem[0..N-1]`. Counters: `wr_idx`, `pass`, `j`, `rd_idx`.
- FSM states: FILL, SORT, DRAIN. State after reset is FILL.
- FILL
  - `in_ready` = 1.
  - On `in_valid && in_ready`: `mem[wr_idx] <= in_data`, `wr_idx++`.
  - On the N-th accepted word: go to SORT with `pass = 0`, `j = 0`.
- SORT
  - `in_ready` = 0.
  - Each cycle, the comparator evaluates `a = mem[j]`, `b = mem[j+1]`.
  - If `c` = 1, the two entries are swapped at the clock edge. Equal values are never swapped, so the sort is stable.
  - `j` runs 0..N-2-pass. At the end of each pass: `pass++`, `j = 0`.
  - After pass N-2 completes: go to DRAIN with `rd_idx = 0`.
- DRAIN
  - `out_valid` = 1, `out_data = mem[rd_idx]`.
  - On `out_valid && out_ready`: `rd_idx++`.
  - On the N-th transfer: go to FILL with `wr_idx = 0`.
- The handshakes on both ports follow standard valid/ready rules:
  - `out_valid` and `out_data` stay stable until accepted.
  - `in_valid` while `in_ready` = 0 is ignored; no data is lost, and the producer holds the word.

## Timing
- Reset values (asserted immediately on `rst_n` low):
  - State FILL; all counters 0; `mem` cleared to 0.
  - `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `busy` = 0.
- `in_ready`, `out_valid` and `busy` are decoded directly from registered state, with no combinational path from `in_valid` or `out_ready`.
- Let T be the cycle in which the N-th input word is accepted:
  - SORT occupies cycles T+1 .. T+N(N-1)/2.
  - `out_valid` first rises in cycle T+N(N-1)/2+1. For N=4 this is T+7.
- DRAIN with `out_ready` held at 1: one word per cycle, N cycles.
  - `in_ready` rises in the cycle after the last output transfer.
  - FILL and DRAIN never overlap.
- Reset asserted mid-burst (any state): the partial burst is discarded and the block returns to the reset values. No output word is emitted afterward.
- `out_ready` held low in DRAIN: the block holds indefinitely with no timeout.

## Configuration
- `CMP_SORT_EARLY_EXIT_EN`
  - Defined: a per-pass `swapped` flag is kept. If a pass completes with no swaps, the block goes to DRAIN in the next cycle.
    - Already-sorted N=4 input: `out_valid` rises at T+4.
    - Worst case is unchanged: T+N(N-1)/2+1.
  - Undefined: fixed latency, exactly N(N-1)/2 SORT cycles regardless of data. No `swapped` flag logic is present.

## Test plan
- Reset, then N=4 input 8'd9, 8'd3, 8'd7, 8'd1, `out_ready` = 1 → outputs 1, 3, 7, 9; `out_valid` first high at T+7; `busy` high T+1..T+10.
- Duplicates 8'd5, 8'd2, 8'd5, 8'd2 → outputs 2, 2, 5, 5. Sorted input 1, 2, 3, 4 → unchanged; `out_valid` at T+7 without the macro, T+4 with it.
- Unsigned extremes 8'hFF, 8'h00, 8'h80, 8'h7F → outputs 00, 7F, 80, FF.
- Backpressure: toggle `out_ready` 1/0 each cycle in DRAIN → each word is held stable until accepted; 4 transfers take 8 cycles. `in_valid` = 1 held throughout SORT/DRAIN is not accepted; `in_ready` = 0 during that period.
- Pull `rst_n` low after 2 words loaded, and again mid-DRAIN → all outputs return to reset values immediately. A fresh burst 4, 3, 2, 1 then yields 1, 2, 3, 4.

Source files
------------

// File: rtl/cmp_sort_ctrl_if.sv
// Valid/ready producer and consumer ports of cmp_sort_ctrl bundled as one interface.
// slave is the sorter side; master is the producer/consumer (or bench) side.
interface cmp_sort_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/cmp_sort_ctrl.sv
// Burst sorter: loads N words, bubble-sorts them with one shared comparator, streams them out.
// Optional macro CMP_SORT_EARLY_EXIT_EN: leave SORT after the first pass that makes no swap.
module cmp_sort_ctrl #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  cmp_sort_ctrl_if.slave     bus,
  output logic               busy
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
  localparam logic [CW-1:0] LAST_PASS = CW'(N - 2);

  typedef enum logic [1:0] {S_FILL, S_SORT, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    wr_idx_q, wr_idx_d;
  logic [CW-1:0]    pass_q, pass_d;
  logic [CW-1:0]    j_q, j_d;
  logic [CW-1:0]    rd_idx_q, rd_idx_d;
  logic [WIDTH-1:0] mem_q [N];
  logic [WIDTH-1:0] mem_d [N];

  logic [CW-1:0]    j_p1;
  logic [WIDTH-1:0] cmp_a, cmp_b;
  logic             cmp_c;
  logic             last_j;
  logic             pass_clean;

  // The single shared comparator looks at the adjacent pair under j.
  assign j_p1   = j_q + CW'(1);
  assign cmp_a  = mem_q[j_q];
  assign cmp_b  = mem_q[j_p1];
  assign cmp_c  = (cmp_a > cmp_b);
  assign last_j = (j_q == (LAST_PASS - pass_q));

`ifdef CMP_SORT_EARLY_EXIT_EN
  logic swapped_q, swapped_d;

  assign pass_clean = !(swapped_q || cmp_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) swapped_q <= 1'b0;
    else        swapped_q <= swapped_d;
  end
`else
  assign pass_clean = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    pass_d   = pass_q;
    j_d      = j_q;
    rd_idx_d = rd_idx_q;
    mem_d    = mem_q;
`ifdef CMP_SORT_EARLY_EXIT_EN
    swapped_d = swapped_q;
`endif
    case (state_q)
      S_FILL: begin
        if (bus.in_valid) begin
          mem_d[wr_idx_q] = bus.in_data;
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d = '0;
            pass_d   = '0;
            j_d      = '0;
            state_d  = S_SORT;
`ifdef CMP_SORT_EARLY_EXIT_EN
            swapped_d = 1'b0;
`endif
          end else begin
            wr_idx_d = wr_idx_q + CW'(1);
          end
        end
      end
      S_SORT: begin
        // Strict greater-than: equal words stay in place, keeping the sort stable.
        if (cmp_c) begin
          mem_d[j_q]  = cmp_b;
          mem_d[j_p1] = cmp_a;
        end
`ifdef CMP_SORT_EARLY_EXIT_EN
        swapped_d = swapped_q | cmp_c;
`endif
        if (last_j) begin
          j_d = '0;
`ifdef CMP_SORT_EARLY_EXIT_EN
          swapped_d = 1'b0;
`endif
          if ((pass_q == LAST_PASS) || pass_clean) begin
            pass_d   = '0;
            rd_idx_d = '0;
            state_d  = S_DRAIN;
          end else begin
            pass_d = pass_q + CW'(1);
          end
        end else begin
          j_d = j_p1;
        end
      end
      S_DRAIN: begin
        if (bus.out_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d = '0;
            wr_idx_d = '0;
            state_d  = S_FILL;
          end else begin
            rd_idx_d = rd_idx_q + CW'(1);
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FILL;
      wr_idx_q <= '0;
      pass_q   <= '0;
      j_q      <= '0;
      rd_idx_q <= '0;
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      pass_q   <= pass_d;
      j_q      <= j_d;
      rd_idx_q <= rd_idx_d;
      mem_q    <= mem_d;
    end
  end

  // Handshake outputs depend only on registered state.
  assign bus.in_ready  = (state_q == S_FILL);
  assign bus.out_valid = (state_q == S_DRAIN);
  assign bus.out_data  = (state_q == S_DRAIN) ? mem_q[rd_idx_q] : '0;
  assign busy          = (state_q == S_SORT) || (state_q == S_DRAIN);
endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Scoreboard bench for cmp_sort_ctrl (N=4, WIDTH=8): expected sorted words are queued
// when a burst is driven and popped as the DUT streams them out.
module tb_cmp_sort_ctrl;
  typedef logic [7:0] burst_t [4];

  logic clk;
  logic rst_n;
  logic busy;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic [7:0] exp_q [$];

  cmp_sort_ctrl_if #(.WIDTH(8)) bus ();

  cmp_sort_ctrl #(.N(4), .WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic send_word(input logic [7:0] w);
    @(negedge clk);
    chk("in_ready_fill", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    $display("in  word=%02h cycle=%0d", w, cyc);
  endtask

  // Drive one burst, check latency/busy/in_ready, then drain against the scoreboard.
  task automatic run_burst(input burst_t w, input int exp_lat, input bit toggle, input bit hold_valid);
    logic [7:0] tmp [$];
    int t0, n, xfers, dcyc;
    logic [7:0] prev;
    bit stalled;
    for (int i = 0; i < 4; i++) tmp.push_back(w[i]);
    tmp.sort();
    foreach (tmp[i]) exp_q.push_back(tmp[i]);

    for (int i = 0; i < 4; i++) send_word(w[i]);
    t0 = cyc;
    @(negedge clk);
    if (hold_valid) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hAA;
    end else begin
      bus.in_valid = 1'b0;
    end

    n = 0;
    while (!bus.out_valid && n < 40) begin
      chk("in_ready_sort", bus.in_ready, 0);
      chk("busy_sort", busy, 1);
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      chk("out_valid_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    chk("latency", cyc - t0, exp_lat);

    xfers = 0;
    dcyc = 0;
    stalled = 1'b0;
    prev = '0;
    while (xfers < 4 && dcyc < 40) begin
      bus.out_ready = toggle ? ((dcyc % 2) == 1) : 1'b1;
      chk("out_valid_drain", bus.out_valid, 1);
      chk("in_ready_drain", bus.in_ready, 0);
      chk("busy_drain", busy, 1);
      if (stalled) chk("hold_data", bus.out_data, prev);
      if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("out_data", bus.out_data, e);
          $display("out word=%02h expected=%02h cycle=%0d", bus.out_data, e, cyc);
        end
        xfers++;
        if (xfers == 4) bus.in_valid = 1'b0;
      end
      prev = bus.out_data;
      stalled = !bus.out_ready;
      @(negedge clk);
      dcyc++;
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("drain_xfers", xfers, 4);
    chk("drain_cycles", dcyc, toggle ? 8 : 4);
    chk_idle("after_drain");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    burst_t b;
    int n;
    int sorted_lat;
`ifdef CMP_SORT_EARLY_EXIT_EN
    sorted_lat = 4;
`else
    sorted_lat = 7;
`endif
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #1;
    chk_idle("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    b = '{8'd9, 8'd3, 8'd7, 8'd1};       run_burst(b, 7, 1'b0, 1'b0);
    b = '{8'd5, 8'd2, 8'd5, 8'd2};       run_burst(b, 7, 1'b0, 1'b0);
    b = '{8'd1, 8'd2, 8'd3, 8'd4};       run_burst(b, sorted_lat, 1'b0, 1'b0);
    b = '{8'hFF, 8'h00, 8'h80, 8'h7F};   run_burst(b, 7, 1'b0, 1'b0);
    b = '{8'h40, 8'h10, 8'h30, 8'h20};   run_burst(b, 7, 1'b1, 1'b1);

    // Reset after two words loaded: partial burst must vanish.
    send_word(8'd10);
    send_word(8'd20);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_idle("rst_fill");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-drain: no further word may be emitted.
    send_word(8'd8); send_word(8'd6); send_word(8'd4); send_word(8'd2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("mid_drain_reached", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    chk("mid_drain_first", bus.out_data, 8'd2);
    @(negedge clk);
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_idle("rst_drain");
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_output_after_rst", bus.out_valid, 0);
    end
    bus.out_ready = 1'b0;

    b = '{8'd4, 8'd3, 8'd2, 8'd1};       run_burst(b, 7, 1'b0, 1'b0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
